// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, comparison flag positions and the
// response record carried through the arbiter's response FIFO.
package alu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   localparam int CMP_EQ  = 5;
   localparam int CMP_NE  = 4;
   localparam int CMP_LTU = 3;
   localparam int CMP_LT  = 2;
   localparam int CMP_GEU = 1;
   localparam int CMP_GES = 0;

   localparam int RSP_W = 39;

   typedef struct packed {
      logic [31:0] result;
      logic [5:0]  cmp;
      logic        id;
   } rsp_t;

endpackage

// File: rtl/alu_rsp_fifo.sv
// Response FIFO: power-of-two circular buffer with an explicit occupancy
// count, so full and empty are unambiguous when the pointers coincide.
module alu_rsp_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 39
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW-1:0] PTR_ONE  = 1;
   localparam logic [AW:0]   CNT_ONE  = 1;
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
   logic [AW-1:0]               wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]               rd_ptr_q, rd_ptr_d;
   logic [AW:0]                 count_q, count_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // push and pop together leave occupancy alone, even when full
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_data = mem_q[rd_ptr_q];
   assign empty     = (count_q == '0);
   assign full      = (count_q == CNT_FULL);

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU;
// results are captured into a response FIFO tagged with the requester id.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int RSP_DEPTH = 2
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Req0_Valid,
   output logic        Req0_Ready,
   input  logic [31:0] Req0_LHS,
   input  logic [31:0] Req0_RHS,
   input  logic [3:0]  Req0_Function,
   input  logic        Req1_Valid,
   output logic        Req1_Ready,
   input  logic [31:0] Req1_LHS,
   input  logic [31:0] Req1_RHS,
   input  logic [3:0]  Req1_Function,
   output logic [31:0] ALU_LHS,
   output logic [31:0] ALU_RHS,
   output logic [3:0]  ALU_Function,
   input  logic [31:0] ALU_Result,
   input  logic [5:0]  ALU_Comparisons,
   output logic        Rsp_Valid,
   input  logic        Rsp_Ready,
   output logic [31:0] Rsp_Result,
   output logic [5:0]  Rsp_Comparisons,
   output logic        Rsp_Id
);

   logic last_grant_q, last_grant_d;
   logic gnt, gnt_idx, space, pop;
   logic fifo_empty, fifo_full;
   rsp_t push_rsp, head_rsp;

   always_comb begin
      pop     = !Reset && !fifo_empty && Rsp_Ready;
      // a full FIFO is never empty, so Rsp_Ready guarantees a pop frees a slot
      space   = !fifo_full || Rsp_Ready;
      gnt_idx = (Req0_Valid && Req1_Valid) ? ~last_grant_q : Req1_Valid;
      gnt     = !Reset && space && (Req0_Valid || Req1_Valid);

      last_grant_d = gnt ? gnt_idx : last_grant_q;
      Req0_Ready   = gnt && !gnt_idx;
      Req1_Ready   = gnt && gnt_idx;

      ALU_LHS      = '0;
      ALU_RHS      = '0;
      ALU_Function = '0;
      if (gnt) begin
         if (gnt_idx) begin
            ALU_LHS      = Req1_LHS;
            ALU_RHS      = Req1_RHS;
            ALU_Function = Req1_Function;
         end else begin
            ALU_LHS      = Req0_LHS;
            ALU_RHS      = Req0_RHS;
            ALU_Function = Req0_Function;
         end
      end

      push_rsp = '{result: ALU_Result, cmp: ALU_Comparisons, id: gnt_idx};
   end

   always_ff @(posedge Clock) begin
      if (Reset) last_grant_q <= 1'b1;
      else       last_grant_q <= last_grant_d;
   end

   alu_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .WIDTH (RSP_W)
   ) u_rsp_fifo (
      .clk       (Clock),
      .rst       (Reset),
      .push      (gnt),
      .push_data (push_rsp),
      .pop       (pop),
      .head_data (head_rsp),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign Rsp_Valid       = !Reset && !fifo_empty;
   assign Rsp_Result      = head_rsp.result;
   assign Rsp_Comparisons = head_rsp.cmp;
   assign Rsp_Id          = head_rsp.id;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RSP_DEPTH, 2, response FIFO entries; SHALL be a power of two, >= 2.
REQ-002 Clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset  in  1  synchronous, active-high reset.
REQ-004 ReqN_Valid  in  1  requester N (N = 0, 1) presents an operation.
REQ-005 ReqN_Ready  out  1  operation from requester N accepted this cycle.
REQ-006 ReqN_LHS, ReqN_RHS  in  32 each  operands from requester N.
REQ-007 ReqN_Function  in  4  ALU function code from requester N.
REQ-008 ALU_LHS, ALU_RHS  out  32 each  operands driven to the shared ALU.
REQ-009 ALU_Function  out  4  function code driven to the shared ALU.
REQ-010 ALU_Result  in  32; ALU_Comparisons  in  6  combinational ALU outputs.
REQ-011 Rsp_Valid  out  1; Rsp_Ready  in  1  response handshake.
REQ-012 Rsp_Result  out  32; Rsp_Comparisons  out  6; Rsp_Id  out  1  response payload and originating requester.

Function
REQ-013 Transfer on a port SHALL occur only in a cycle where Valid and Ready are both 1; requesters SHALL hold Valid and payload stable until transfer and SHALL NOT derive Valid from Ready.
REQ-014 At most one request SHALL be granted per cycle; a grant SHALL occur only when the FIFO has space: count < RSP_DEPTH, or count == RSP_DEPTH and Rsp_Ready == 1.
REQ-015 Arbitration SHALL be round-robin: register LastGrant; if both valid, grant the requester != LastGrant; if one valid, grant it; LastGrant updates only on a grant.
REQ-016 ReqN_Ready SHALL be 1 only for the granted requester; it may depend combinationally on both Valids and Rsp_Ready.
REQ-017 In a grant cycle, ALU_LHS/RHS/Function SHALL equal the granted requester's payload combinationally; otherwise all SHALL be 0.
REQ-018 In a grant cycle, {ALU_Result, ALU_Comparisons, granted index} SHALL be pushed into the FIFO at the clock edge.
REQ-019 Latency: request accepted at edge k SHALL appear on Rsp_* from edge k onward (Rsp_Valid high the following cycle) when the FIFO was empty.
REQ-020 Responses SHALL emerge in grant order; Rsp_* SHALL present the FIFO head; pop SHALL occur on Rsp_Valid && Rsp_Ready.
REQ-021 Simultaneous push and pop SHALL leave count unchanged, including at count == RSP_DEPTH and count == 1.
REQ-022 FIFO read/write pointers SHALL wrap modulo RSP_DEPTH; count SHALL be log2(RSP_DEPTH)+1 bits.
REQ-023 Function codes SHALL pass through unmodified; undefined codes SHALL be accepted and return the ALU's result (0).
REQ-024 Rsp_Payload SHALL be undefined-but-stable when Rsp_Valid == 0 (driven from head entry, no X from uninitialised storage required).

Reset
REQ-025 While Reset == 1: Rsp_Valid = 0, Req0_Ready = Req1_Ready = 0, ALU_* = 0, FIFO count and pointers = 0, LastGrant = 1.
REQ-026 Reset mid-operation SHALL discard all buffered responses; no response SHALL emerge for requests accepted before reset.
REQ-027 First cycle after reset release SHALL arbitrate normally (requester 0 wins a tie).

Structure
REQ-028 Shared package alu_pkg SHALL hold ALU function-code constants (ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111) and comparison bit indices (EQ 5, NE 4, LTU 3, LT 2, GEU 1, GES 0).
REQ-029 Response FIFO SHALL be a sub-module alu_rsp_fifo (parameter DEPTH, WIDTH = 39); arbitration logic SHALL remain in alu_arbiter.

Verification
REQ-030 Reset, Req0 ADD 5, 7 -> Req0_Ready same cycle; next cycle Rsp_Valid=1, Result 12, Comparisons 6'b011100, Id 0.
REQ-031 Both requesters valid continuously, Rsp_Ready=1, 4 ops -> grants 0,1,0,1; one response per cycle; Ids 0,1,0,1.
REQ-032 Rsp_Ready=0, Req0 valid -> two accepts then Ready=0; raise Rsp_Ready with FIFO full -> pop and push same cycle, count stays 2, order preserved.
REQ-033 Req1 SRA 0x80000000, 4 -> 0xF8000000; SLT 0xFFFFFFFF, 1 -> 1; SLTU same operands -> 0; function 1111 -> Result 0, Comparisons valid.
REQ-034 Two entries buffered, assert Reset one cycle -> Rsp_Valid 0 next cycle, entries lost; tie after release granted to requester 0.
